// File: rtl/seven_seg_display.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with decimal points.
// Latency: one clk from counter/inputs to seg/an registers; each digit is lit for 2**(CTR_BITS-2) clks.
// Backpressure: none; pure output block that refreshes continuously from its inputs.
//
// Ports:
//   clk              rising-edge system clock
//   rstn             asynchronous reset, active HIGH (legacy name)
//   display_0..3     per-digit value, only [3:0] shown (digit 0 = rightmost, an[0])
//   decplace         index of the digit whose decimal point is lit
//   seg              active-low segments, seg[7]=dp, seg[6:0]=g..a
//   an               active-low digit enables, exactly one low after reset
module seven_seg_display #(
  parameter int CTR_BITS = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [CTR_BITS-1:0] r_cnt;
  logic [7:0]          r_seg;
  logic [3:0]          r_an;
  logic [1:0]          w_idx;
  logic [3:0]          w_nib;
  logic [6:0]          w_hex;
  logic                w_dp_on;

  // Upper nibbles are intentionally not displayed.
  logic [15:0] w_unused_hi;
  assign w_unused_hi = {display_3[7:4], display_2[7:4], display_1[7:4], display_0[7:4]};

  // Top two counter bits pick the digit being scanned.
  assign w_idx   = r_cnt[CTR_BITS-1 -: 2];
  assign w_dp_on = (w_idx == decplace);

  always_comb begin
    w_nib = display_0[3:0];
    case (w_idx)
      2'd0: w_nib = display_0[3:0];
      2'd1: w_nib = display_1[3:0];
      2'd2: w_nib = display_2[3:0];
      2'd3: w_nib = display_3[3:0];
      default: w_nib = display_0[3:0];
    endcase
  end

  // Active-high gfedcba pattern for a hex nibble.
  always_comb begin
    w_hex = 7'h00;
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
  end

  // an and seg are registered together from the same counter value, so the
  // enabled digit and its segment pattern always change on the same edge.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_cnt <= '0;
      r_seg <= 8'hFF;
      r_an  <= 4'hF;
    end else begin
      r_cnt <= r_cnt + {{(CTR_BITS-1){1'b0}}, 1'b1};
      r_an  <= ~(4'b0001 << w_idx);
      r_seg <= {~w_dp_on, ~w_hex};
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seven_seg_display.sv
module tb_seven_seg_display;

  localparam int CB      = 4;
  localparam int DIG_CYC = 2 ** (CB - 2);

  logic       clk;
  logic       rstn;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;

  logic [6:0] hexpat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_display #(.CTR_BITS(CB)) dut (
    .clk(clk), .rstn(rstn),
    .display_0(display_0), .display_1(display_1),
    .display_2(display_2), .display_3(display_3),
    .decplace(decplace), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count edges since reset release; the digit shown after
  // an edge is (edges_before / cycles_per_digit) mod 4, using inputs at that edge.
  int         m_cycle;
  int         m_d;
  logic [7:0] m_v;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;

  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      m_cycle = 0;
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
    end else begin
      m_d = (m_cycle / DIG_CYC) % 4;
      case (m_d)
        0: m_v = display_0;
        1: m_v = display_1;
        2: m_v = display_2;
        default: m_v = display_3;
      endcase
      exp_an  = 4'hF ^ 4'(1 << m_d);
      exp_seg = {(m_d != int'(decplace)), ~hexpat[m_v[3:0]]};
      m_cycle = m_cycle + 1;
    end
  end

  // Hold reset two cycles, release on a falling edge.
  task automatic do_reset();
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (seg !== 8'hFF || an !== 4'hF) begin
        bad++;
        $display("FAIL reset_hold: seg=%h an=%b want seg=ff an=1111", seg, an);
      end
    end
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 4'b1110) begin
      bad++;
      $display("FAIL reset_release: an=%b want 1110", an);
    end
  endtask

  task automatic test_scan();
    logic [7:0] seg_tab [4];
    logic [3:0] an_tab  [4];
    int d;
    seg_tab = '{8'hF9, 8'hA4, 8'hB0, 8'h19};   // digit 3 carries the lit dp
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    display_0 = 8'h01; display_1 = 8'h02; display_2 = 8'h03; display_3 = 8'h04;
    decplace  = 2'b11;
    do_reset();
    // Three full scans, crossing the counter wrap twice.
    for (int j = 0; j < 3 * 4 * DIG_CYC; j++) begin
      @(negedge clk);
      d = (j / DIG_CYC) % 4;
      total++;
      if (an !== an_tab[d] || seg !== seg_tab[d]) begin
        bad++;
        $display("FAIL scan[%0d]: seg=%h an=%b want seg=%h an=%b", j, seg, an, seg_tab[d], an_tab[d]);
      end
    end
  endtask

  task automatic test_dp();
    logic [7:0] want;
    display_0 = 8'h00; display_1 = 8'h00; display_2 = 8'h00; display_3 = 8'h00;
    decplace  = 2'b10;
    do_reset();
    for (int j = 0; j < 4 * DIG_CYC; j++) begin
      @(negedge clk);
      want = (an == 4'b1011) ? 8'h40 : 8'hC0;
      total++;
      if (seg !== want || an !== exp_an) begin
        bad++;
        $display("FAIL dp[%0d]: seg=%h an=%b want seg=%h an=%b", j, seg, an, want, exp_an);
      end
    end
  endtask

  task automatic test_decode();
    logic [7:0] up;
    logic [3:0] nib;
    decplace = 2'b01;
    for (int u = 0; u < 2; u++) begin
      up = (u == 0) ? 8'h00 : 8'hF0;
      for (int v = 0; v < 16; v++) begin
        nib = 4'(v);
        display_0 = up | {4'h0, nib};
        do_reset();
        @(negedge clk);
        total++;
        if (an !== 4'b1110 || seg[6:0] !== ~hexpat[v] || seg[7] !== 1'b1) begin
          bad++;
          $display("FAIL decode[%h]: seg=%h an=%b want seg=%h an=1110",
                   display_0, seg, an, {1'b1, ~hexpat[v]});
        end
      end
    end
    display_0 = 8'h0A;
    do_reset();
    @(negedge clk);
    total++;
    if (seg[6:0] !== 7'h08) begin
      bad++;
      $display("FAIL decode_A: seg[6:0]=%h want 08", seg[6:0]);
    end
  endtask

  task automatic test_random();
    display_0 = 8'($urandom); display_1 = 8'($urandom);
    display_2 = 8'($urandom); display_3 = 8'($urandom);
    decplace  = 2'($urandom);
    do_reset();
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      total++;
      if (seg !== exp_seg || an !== exp_an) begin
        bad++;
        $display("FAIL random[%0d]: seg=%h an=%b want seg=%h an=%b", j, seg, an, exp_seg, exp_an);
      end
      total++;
      if ($countones(~an) != 1) begin
        bad++;
        $display("FAIL onehot[%0d]: an=%b want exactly one low bit", j, an);
      end
      if ($urandom_range(0, 3) == 0) display_0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) display_1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) display_2 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) display_3 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) decplace  = 2'($urandom);
    end
  endtask

  task automatic test_midreset();
    int  n;
    display_0 = 8'h05; display_1 = 8'h06; display_2 = 8'h07; display_3 = 8'h08;
    decplace  = 2'b00;
    do_reset();
    // Run past one wrap, then stop inside digit 2.
    repeat (4 * DIG_CYC) @(negedge clk);
    n = 0;
    while (an !== 4'b1011 && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (an !== 4'b1011) begin
      bad++;
      $display("FAIL midreset_reach: an=%b want 1011 within 64 cycles", an);
    end
    @(posedge clk);
    #2 rstn = 1'b1;
    #1;
    total++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      bad++;
      $display("FAIL midreset_async: seg=%h an=%b want seg=ff an=1111", seg, an);
    end
    @(negedge clk);
    total++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      bad++;
      $display("FAIL midreset_hold: seg=%h an=%b want seg=ff an=1111", seg, an);
    end
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 4'b1110 || seg !== {1'b0, ~hexpat[5]}) begin
      bad++;
      $display("FAIL midreset_restart: seg=%h an=%b want seg=%h an=1110", seg, an, {1'b0, ~hexpat[5]});
    end
  endtask

  initial begin
    rstn = 1'b1;
    display_0 = 8'h00; display_1 = 8'h00; display_2 = 8'h00; display_3 = 8'h00;
    decplace  = 2'b00;
    test_reset();
    test_scan();
    test_dp();
    test_decode();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
